// File: rtl/pipe_reg.sv
// pipe_reg: a chain of DEPTH WIDTH-bit pipeline stages. Each stage carries a
// valid bit. The chain advances on a global enable, and a flush clears the
// valid bits. A registered occupancy counter tracks how many stages hold
// valid data.
//
// Port protocol: the chain has no backpressure. A word is accepted on every
// rising edge that sees en=1, and d_valid only qualifies it. The word leaves
// on q qualified by q_valid. en=0 freezes every stage, every valid bit and the
// counter.
module pipe_reg #(
    parameter int               WIDTH        = 4,
    parameter int               DEPTH        = 3,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0,
    parameter bit               GATE_INVALID = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           d,
    input  logic                       d_valid,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] valid_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;

    // Data stages load on every enabled edge, whatever d_valid says.
    // Flush never touches data; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= RESET_VAL;
            end
        end else if (en) begin
            data[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                data[i] <= data[i-1];
            end
        end
    end

    // Next valid vector and occupancy. Flush kills everything older than the
    // word entering on the same edge. A plain shift adjusts the count by the
    // word that enters minus the word that leaves, so the count can never
    // exceed DEPTH or wrap.
    always_comb begin
        valid_nxt = valid;
        cnt_nxt   = cnt;
        if (flush) begin
            valid_nxt = '0;
            cnt_nxt   = '0;
            if (en) begin
                valid_nxt[0] = d_valid;
                cnt_nxt      = CW'(d_valid);
            end
        end else if (en) begin
            valid_nxt[0] = d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                valid_nxt[i] = valid[i-1];
            end
            cnt_nxt = cnt + CW'(d_valid) - CW'(valid[DEPTH-1]);
        end
    end

    // Valid bits and counter register; reset has top priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            cnt   <= '0;
        end else begin
            valid <= valid_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign q_valid = valid[DEPTH-1];
    assign count   = cnt;

    // The optional gate on q depends only on the registered last-stage valid.
    generate
        if (GATE_INVALID) begin : g_gate
            assign q = valid[DEPTH-1] ? data[DEPTH-1] : RESET_VAL;
        end else begin : g_nogate
            assign q = data[DEPTH-1];
        end
    endgenerate

endmodule

// File: tb/tb_pipe_reg.sv
// Testbench for pipe_reg: two instances share their inputs, one ungated and
// one with GATE_INVALID=1. Directed vectors carry hand-computed expectations
// for the state after each edge. A monitor checks them one edge later.
module tb_pipe_reg;

    localparam int WIDTH = 4;
    localparam int DEPTH = 3;
    localparam logic [3:0] RV = 4'hA;

    logic       clk = 1'b0;
    logic       reset, en, flush, d_valid;
    logic [3:0] d;
    logic [3:0] q, qg;
    logic       q_valid, qg_valid;
    logic [1:0] count, countg;

    // expected entry: {q, q_valid, count, gated q}
    logic [10:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // clock / reset block
    always #5 clk = ~clk;

    pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV), .GATE_INVALID(1'b0)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q), .q_valid(q_valid), .count(count)
    );

    pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV), .GATE_INVALID(1'b1)) dut_g (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(qg), .q_valid(qg_valid), .count(countg)
    );

    // driver: set inputs for the next edge and queue the state expected after it
    task automatic step(input logic r, input logic e, input logic f, input logic [3:0] dd,
                        input logic dv, input logic [3:0] eq, input logic eqv,
                        input logic [1:0] ec, input logic [3:0] eqg);
        @(negedge clk);
        reset   = r;
        en      = e;
        flush   = f;
        d       = dd;
        d_valid = dv;
        exp_q.push_back({eq, eqv, ec, eqg});
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // monitor / scoreboard: compare just after each rising edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [10:0] e;
            e = exp_q.pop_front();
            check("q",        q,                 e[10:7]);
            check("q_valid",  {3'b0, q_valid},   {3'b0, e[6]});
            check("count",    {2'b0, count},     {2'b0, e[5:4]});
            check("gated_q",  qg,                e[3:0]);
            check("gated_qv", {3'b0, qg_valid},  {3'b0, e[6]});
            check("gated_cnt",{2'b0, countg},    {2'b0, e[5:4]});
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; flush = 1'b0; d = '0; d_valid = 1'b0;

        // reset with random inputs
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 RV, 1'b0, 2'd0, RV);
        end

        // fill and drain: 1,2,3,4 then bubbles
        step(0, 1, 0, 4'h1, 1, RV,   0, 2'd1, RV);
        step(0, 1, 0, 4'h2, 1, RV,   0, 2'd2, RV);
        step(0, 1, 0, 4'h3, 1, 4'h1, 1, 2'd3, 4'h1);
        step(0, 1, 0, 4'h4, 1, 4'h2, 1, 2'd3, 4'h2);
        step(0, 1, 0, 4'h0, 0, 4'h3, 1, 2'd2, 4'h3);
        step(0, 1, 0, 4'h0, 0, 4'h4, 1, 2'd1, 4'h4);
        step(0, 1, 0, 4'h0, 0, 4'h0, 0, 2'd0, RV);

        // stall: fill 5,6,7 then hold while d toggles
        step(0, 1, 0, 4'h5, 1, 4'h0, 0, 2'd1, RV);
        step(0, 1, 0, 4'h6, 1, 4'h0, 0, 2'd2, RV);
        step(0, 1, 0, 4'h7, 1, 4'h5, 1, 2'd3, 4'h5);
        step(0, 0, 0, 4'hF, 1, 4'h5, 1, 2'd3, 4'h5);
        step(0, 0, 0, 4'h0, 1, 4'h5, 1, 2'd3, 4'h5);
        step(0, 0, 0, 4'hF, 1, 4'h5, 1, 2'd3, 4'h5);
        step(0, 0, 0, 4'h0, 1, 4'h5, 1, 2'd3, 4'h5);
        step(0, 1, 0, 4'h0, 0, 4'h6, 1, 2'd2, 4'h6);
        step(0, 1, 0, 4'h0, 0, 4'h7, 1, 2'd1, 4'h7);
        step(0, 1, 0, 4'h0, 0, 4'h0, 0, 2'd0, RV);

        // flush with simultaneous entry of C
        step(0, 1, 0, 4'h8, 1, 4'h0, 0, 2'd1, RV);
        step(0, 1, 0, 4'h9, 1, 4'h0, 0, 2'd2, RV);
        step(0, 1, 0, 4'hB, 1, 4'h8, 1, 2'd3, 4'h8);
        step(0, 1, 1, 4'hC, 1, 4'h9, 0, 2'd1, RV);
        step(0, 1, 0, 4'h0, 0, 4'hB, 0, 2'd1, RV);
        step(0, 1, 0, 4'h0, 0, 4'hC, 1, 2'd1, 4'hC);
        step(0, 1, 0, 4'h0, 0, 4'h0, 0, 2'd0, RV);

        // flush while stalled, repeated: valid cleared, data kept
        step(0, 1, 0, 4'hD, 1, 4'h0, 0, 2'd1, RV);
        step(0, 0, 1, 4'h7, 1, 4'h0, 0, 2'd0, RV);
        step(0, 0, 1, 4'h7, 1, 4'h0, 0, 2'd0, RV);
        step(0, 1, 0, 4'h0, 0, 4'h0, 0, 2'd0, RV);
        step(0, 1, 0, 4'h0, 0, 4'hD, 0, 2'd0, RV);

        // invalid data 5 passes through: ungated shows it, gated shows RESET_VAL
        step(0, 1, 0, 4'h5, 0, 4'h0, 0, 2'd0, RV);
        step(0, 1, 0, 4'h5, 0, 4'h0, 0, 2'd0, RV);
        step(0, 1, 0, 4'h5, 0, 4'h5, 0, 2'd0, RV);

        // reset mid-stream with two words in flight
        step(0, 1, 0, 4'h1, 1, 4'h5, 0, 2'd1, RV);
        step(0, 1, 0, 4'h2, 1, 4'h5, 0, 2'd2, RV);
        step(1, 1, 0, 4'h3, 1, RV,   0, 2'd0, RV);
        step(0, 1, 0, 4'h0, 0, RV,   0, 2'd0, RV);
        step(0, 1, 0, 4'h0, 0, RV,   0, 2'd0, RV);
        step(0, 1, 0, 4'h0, 0, 4'h0, 0, 2'd0, RV);

        // let the monitor drain the queue, bounded
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_reg.md
# pipe_reg

Parametrised, clock-edge pipeline register chain. DEPTH stages of WIDTH-bit data, each with a valid bit, a global advance enable (stall when low), a flush and a live occupancy count. It is the synchronous, multi-stage successor to the team's 4-bit level-sensitive holding register. It sits between datapath blocks that need a fixed, stallable delay with valid tracking.

## Interface
- WIDTH, 4: data width in bits, ≥1.
- DEPTH, 3: number of stages, ≥1; nominal latency in enabled cycles.
- RESET_VAL, 0: value loaded into every data stage on reset (WIDTH bits).
- GATE_INVALID, 0: if 1, q is driven to RESET_VAL whenever q_valid=0; if 0, q shows the last-stage data unconditionally.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  advance; 1 = shift all stages by one, 0 = hold everything.
- flush  in  1  clears all valid bits.
- d  in  WIDTH  input data to stage 0.
- d_valid  in  1  valid flag accompanying d.
- q  out  WIDTH  last-stage data (gated per GATE_INVALID).
- q_valid  out  1  last-stage valid bit.
- count  out  $clog2(DEPTH+1)  number of stages currently holding valid data.

## Operation
- State: data[0..DEPTH-1], valid[0..DEPTH-1], count register.
- Per-edge priority is reset > flush > en > hold.
- reset=1:
  - every data[i] ← RESET_VAL.
  - every valid[i] ← 0.
  - count ← 0.
- flush=1, en=0:
  - every valid[i] ← 0 and count ← 0.
  - data stages hold their values.
- flush=1, en=1:
  - data shifts normally (data[0] ← d, data[i] ← data[i-1]).
  - all valid[i] ← 0 except valid[0] ← d_valid.
  - count ← d_valid.
  - The word entering on the flush edge survives; everything older is killed.
- en=1, no flush:
  - data[0] ← d and valid[0] ← d_valid.
  - data[i] ← data[i-1] and valid[i] ← valid[i-1] for i≥1.
  - count ← count + d_valid − valid[DEPTH-1] (old value). Simultaneous entry and exit leaves count unchanged.
- en=0, no flush: all state holds. d and d_valid are ignored.
- Data is loaded on every enabled edge regardless of d_valid. Valid bits only qualify the data.
- count is a registered counter. It must equal the popcount of valid[] after every edge, and never exceed DEPTH or wrap.
- DEPTH=1 degenerates to a single enabled register with valid; the rules above still apply.

## Timing
- Outputs come straight from registers; there is no combinational path from any input to q, q_valid or count.
  - Exception: when GATE_INVALID=1, the q gate is combinational from registered valid[DEPTH-1] only.
- After reset:
  - q = RESET_VAL.
  - q_valid = 0.
  - count = 0.
- Latency: a word presented with en=1 at edge N appears on q after edge N+DEPTH−1, provided en=1 on every intervening edge. Each en=0 edge adds one cycle.
- Throughput: one word per enabled edge; no bubbles are inserted.
- Reset mid-stream discards all in-flight words on that edge, regardless of en or flush.
- flush asserted while en=0 for several cycles is idempotent.

## Test plan
- Reset values: assert reset 2 cycles with random d/en/flush (WIDTH=4, DEPTH=3, RESET_VAL=4'hA) -> q=4'hA, q_valid=0, count=0.
- Fill and drain: en=1, d_valid=1, d=1,2,3,4 on consecutive edges, then d_valid=0 -> q=1,2,3,4 on edges 3..6 with q_valid=1; count steps 1,2,3,3, then 2,1,0 while draining.
- Stall: fill with 5,6,7; hold en=0 for 4 cycles while d toggles -> q=5, count=3 held throughout; on re-enable q=6 then 7.
- Flush with simultaneous entry: pipe holds 3 valid words; flush=1, en=1, d=4'hC, d_valid=1 -> next cycle count=1; q_valid=0 until 4'hC reaches q two enabled edges later.
- GATE_INVALID=1: load d=4'h5 with d_valid=0 through all stages -> q stays RESET_VAL, q_valid=0, count=0; with GATE_INVALID=0, q=4'h5.
- Reset mid-operation: assert reset with 2 valid words in flight and en=1 -> next edge count=0, q_valid=0, q=RESET_VAL; neither word ever appears on q.
